// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter between two 64-bit requesters in front of a byte-wide data memory.
// Each doubleword moves as eight consecutive little-endian byte cycles.
module data_mem_arbiter #(
   parameter int unsigned ADDR_W    = 64,
   parameter int unsigned MEM_BYTES = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [63:0]       req0_wdata,
   input  logic              req1_valid,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [63:0]       req1_wdata,
   output logic              done0,
   output logic              done1,
   output logic              err,
   output logic [63:0]       rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [7:0]        mem_rdata
);

   typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

   localparam logic [ADDR_W:0] MemLimit = (ADDR_W+1)'(MEM_BYTES);
   localparam logic [ADDR_W:0] DwLast   = (ADDR_W+1)'(7);

   state_e              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic                last_grant_q, last_grant_d;
   logic                gid_q, gid_d;
   logic                write_q, write_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [63:0]         wdata_q, wdata_d;
   logic                err_q, err_d;
   logic [63:0]         ldbuf_q, ldbuf_d;
   logic [63:0]         rdata_q, rdata_d;

   logic                grant_id;
   logic                sel_write;
   logic [ADDR_W-1:0]   sel_addr;
   logic [63:0]         sel_wdata;
   logic [ADDR_W:0]     end_addr;
   logic                out_of_range;
   logic [63:0]         ld_next;
   logic                xfer_active;

   // Requester 1 wins only when alone or when requester 0 was served last.
   assign grant_id  = req1_valid && (!req0_valid || !last_grant_q);
   assign sel_write = grant_id ? req1_write : req0_write;
   assign sel_addr  = grant_id ? req1_addr  : req0_addr;
   assign sel_wdata = grant_id ? req1_wdata : req0_wdata;

   // Extra top bit keeps addresses near the top of the space from wrapping into range.
   assign end_addr     = {1'b0, sel_addr} + DwLast;
   assign out_of_range = end_addr >= MemLimit;

   always_comb begin
      ld_next                       = ldbuf_q;
      ld_next[{cnt_q, 3'b000} +: 8] = mem_rdata;
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      gid_d        = gid_q;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      err_d        = err_q;
      ldbuf_d      = ldbuf_q;
      rdata_d      = rdata_q;

      unique case (state_q)
         StIdle: begin
            if (req0_valid || req1_valid) begin
               gid_d   = grant_id;
               write_d = sel_write;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               cnt_d   = 3'd0;
               if (out_of_range) begin
                  err_d   = 1'b1;
                  state_d = StDone;
               end else begin
                  err_d   = 1'b0;
                  state_d = StXfer;
               end
            end
         end
         StXfer: begin
            cnt_d = cnt_q + 3'd1;
            if (!write_q) begin
               ldbuf_d = ld_next;
            end
            if (cnt_q == 3'd7) begin
               state_d = StDone;
               // Publish the assembled doubleword so it is already valid in the done cycle.
               if (!write_q) begin
                  rdata_d = ld_next;
               end
            end
         end
         StDone: begin
            last_grant_d = gid_q;
            state_d      = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         cnt_q        <= 3'd0;
         last_grant_q <= 1'b1;
         gid_q        <= 1'b0;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         err_q        <= 1'b0;
         ldbuf_q      <= '0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         gid_q        <= gid_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         err_q        <= err_d;
         ldbuf_q      <= ldbuf_d;
         rdata_q      <= rdata_d;
      end
   end

   // Gating with reset stops the byte in flight from being written on the abort edge.
   assign xfer_active = (state_q == StXfer) && !reset;
   assign mem_we      = xfer_active && write_q;
   assign mem_re      = xfer_active && !write_q;
   assign mem_addr    = xfer_active ? (addr_q + {{(ADDR_W-3){1'b0}}, cnt_q}) : '0;
   assign mem_wdata   = mem_we ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;

   assign done0 = (state_q == StDone) && !gid_q;
   assign done1 = (state_q == StDone) && gid_q;
   assign err   = (state_q == StDone) && err_q;
   assign rdata = rdata_q;

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-requester controller in front of the byte-wide data memory array.
- Accepts 64-bit doubleword load/store requests from requester 0 (load/store unit) and requester 1 (debug/DMA port). Arbitrates round-robin between them.
- Sequences each doubleword as eight consecutive byte accesses on the memory port, little-endian. Returns assembled load data with a one-cycle done pulse.

Parameters:
- ADDR_W, 64, width of request and memory addresses.
- MEM_BYTES, 64, number of bytes in the attached memory; valid byte addresses are 0..MEM_BYTES-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a pending request.
- req0_write  input  1  1 = store, 0 = load.
- req0_addr  input  ADDR_W  byte address of the doubleword (any alignment).
- req0_wdata  input  64  store data.
- req1_valid, req1_write, req1_addr, req1_wdata  input  1/1/ADDR_W/64  same meaning for requester 1.
- done0  output  1  one-cycle pulse: requester 0 transaction complete.
- done1  output  1  one-cycle pulse: requester 1 transaction complete.
- err  output  1  valid with a done pulse: address out of range, no memory access performed.
- rdata  output  64  assembled load data; valid in the done cycle and held until the next done.
- mem_addr  output  ADDR_W  byte address to memory.
- mem_wdata  output  8  byte write data.
- mem_we  output  1  byte write strobe; memory writes on the clk edge while high.
- mem_re  output  1  byte read enable.
- mem_rdata  input  8  combinational read byte for the current mem_addr.

Behaviour:
- Reset: state IDLE. Byte counter 0, last_grant = 1 (requester 0 wins first). done0, done1, err, mem_we and mem_re are 0. mem_addr, mem_wdata and rdata are 0.
- Reset asserted in any state aborts the transaction on the next edge. No done pulse is issued, and no further strobes occur after reset is sampled.
- States: IDLE, XFER, DONE.
- IDLE:
  - If exactly one reqN_valid is high, grant it.
  - If both are high, grant the requester that is not last_grant.
  - On grant, latch addr, write and wdata, and record the granted id.
  - If addr + 7 >= MEM_BYTES (compare computed at ADDR_W+1 bits, so no wrap), set the error flag and go to DONE.
  - Otherwise clear the counter and go to XFER.
  - With no valid request, stay in IDLE with all strobes low.
- XFER (exactly 8 cycles, counter 0..7):
  - mem_addr = latched addr + counter.
  - Store: mem_we = 1, mem_re = 0, mem_wdata = wdata[8*counter+7 : 8*counter].
  - Load: mem_re = 1, mem_we = 0; on the edge, capture mem_rdata into load buffer bits [8*counter+7 : 8*counter].
  - Counter increments each cycle; after counter = 7, go to DONE.
- DONE (1 cycle):
  - Pulse done of the granted id. err = error flag.
  - rdata = load buffer for a load. For a store or an error, rdata keeps its previous value.
  - last_grant = granted id. Go to IDLE.
- Latency: request sampled in IDLE at edge t. Byte accesses occur in cycles t+1..t+8, done in cycle t+9, and the next grant is sampled at t+10. Error path: done in cycle t+1.
- Requests must hold valid and fields until their done. Fields are latched at grant; later changes, including valid dropping, do not affect an in-flight transaction, and done is still pulsed.
- A requester that keeps valid high after its done is treated as a new request. Round-robin guarantees the other requester is served in between.
- Strobes are never high outside XFER. mem_we and mem_re are never high together.

Test Plan:
- Store then load, requester 0: store addr 8, wdata 0x0123456789ABCDEF -> in cycles t+1..t+8, mem_addr 8..15 with mem_wdata EF,CD,AB,89,67,45,23,01 and mem_we = 1. done0 at t+9, err = 0. A following load at addr 8 -> rdata 0x0123456789ABCDEF with done0.
- Both valid from reset, loads at 0 and 16 -> requester 0 served first (done0 first), then requester 1 (done1 ten cycles later). With both held high, grants alternate 0,1,0,1.
- Unaligned load at addr 3 -> mem_addr sequence 3..10. rdata byte 0 comes from address 3 and byte 7 from address 10.
- Out of range: load at addr 57 (MEM_BYTES = 64) -> done pulses in cycle t+1 with err = 1, mem_re and mem_we stay 0, rdata unchanged. Addr 56 -> normal 8-byte access, err = 0.
- Reset asserted at counter = 4 of a store -> strobes 0 on the next cycle, state IDLE, no done. Bytes 0..3 are written and bytes 4..7 are untouched.
- req1_valid dropped at counter = 2 -> transfer completes all 8 bytes and done1 still pulses.
